// File: rtl/data_memory_arbiter_pkg.sv
// rtl/data_memory_arbiter_pkg.sv - shared widths and FSM encoding for the data memory arbiter
package data_memory_arbiter_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_STROBE = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

endpackage

// File: rtl/data_memory_arbiter_if.sv
// rtl/data_memory_arbiter_if.sv - requester handshakes and memory bus of the arbiter
interface data_memory_arbiter_if #(
    parameter int ADDR_W = data_memory_arbiter_pkg::ADDR_W_DEF,
    parameter int DATA_W = data_memory_arbiter_pkg::DATA_W_DEF
) ();

    logic              req0, req1;
    logic              we0, we1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              ack0, ack1;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic              busy;
    logic              mem_state;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_read, mem_write;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output ack0, ack1, rdata0, rdata1, busy,
               mem_state, mem_addr, mem_wdata, mem_read, mem_write
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  ack0, ack1, rdata0, rdata1, busy,
               mem_state, mem_addr, mem_wdata, mem_read, mem_write
    );

endinterface

// File: rtl/data_memory_arbiter_rr_pick2.sv
// rtl/data_memory_arbiter_rr_pick2.sv - combinational 2-way round-robin picker
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_id,
    output logic       valid
);

    always_comb begin
        valid  = |req;
        gnt_id = 1'b0;
        case (req)
            2'b10:   gnt_id = 1'b1;
            2'b11:   gnt_id = ~last;   // contention: whoever was not granted last
            default: gnt_id = 1'b0;
        endcase
    end

endmodule

// File: rtl/data_memory_arbiter.sv
// rtl/data_memory_arbiter.sv - two-requester round-robin arbiter onto a strobed memory
module data_memory_arbiter
    import data_memory_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                  CLK,
    input  logic                  RST,
    data_memory_arbiter_if.slave  bus
);

    state_t            state_q, state_d;
    logic              id_q, id_d;
    logic              we_q, we_d;
    logic              last_q, last_d;
    logic              ack0_q, ack0_d, ack1_q, ack1_d;
    logic              busy_q, busy_d;
    logic              mem_state_q, mem_state_d;
    logic              mem_read_q, mem_read_d, mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic              gnt_id, gnt_valid;

    rr_pick2 u_pick (
        .req    ({bus.req1, bus.req0}),
        .last   (last_q),
        .gnt_id (gnt_id),
        .valid  (gnt_valid)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            id_q        <= 1'b0;
            we_q        <= 1'b0;
            last_q      <= 1'b1;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            busy_q      <= 1'b0;
            mem_state_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            we_q        <= we_d;
            last_q      <= last_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            busy_q      <= busy_d;
            mem_state_q <= mem_state_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (gnt_valid) state_d = ST_ISSUE;
            ST_ISSUE:  state_d = ST_STROBE;
            ST_STROBE: state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Every output flop is loaded from the state being entered, so outputs
    // line up with the state they belong to without a comb path to the pins.
    always_comb begin
        id_d        = id_q;
        we_d        = we_q;
        last_d      = last_q;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        busy_d      = (state_d != ST_IDLE);
        mem_state_d = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    id_d        = gnt_id;
                    last_d      = gnt_id;
                    we_d        = gnt_id ? bus.we1 : bus.we0;
                    mem_addr_d  = gnt_id ? bus.addr1 : bus.addr0;
                    mem_wdata_d = gnt_id ? bus.wdata1 : bus.wdata0;
                    mem_read_d  = ~we_d;
                    mem_write_d = we_d;
                end
            end
            ST_ISSUE: begin
                mem_state_d = 1'b1;
                mem_read_d  = mem_read_q;
                mem_write_d = mem_write_q;
            end
            ST_STROBE: begin
                ack0_d = ~id_q;
                ack1_d = id_q;
                if (!we_q) begin
                    if (id_q) rdata1_d = bus.mem_rdata;
                    else      rdata0_d = bus.mem_rdata;
                end
            end
            default: ;
        endcase
    end

    assign bus.ack0      = ack0_q;
    assign bus.ack1      = ack1_q;
    assign bus.busy      = busy_q;
    assign bus.mem_state = mem_state_q;
    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.rdata0    = rdata0_q;
    assign bus.rdata1    = rdata1_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// tb/tb_data_memory_arbiter.sv - directed self-checking bench for data_memory_arbiter
module tb_data_memory_arbiter;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    data_memory_arbiter_if bus ();

    data_memory_arbiter dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    // Memory: address a holds a, except address 20 which holds 0xFC.
    logic [7:0] mem [32];
    always @(posedge bus.mem_state or posedge RST) begin
        if (RST) begin
            for (int a = 0; a < 32; a++) mem[a] <= (a == 20) ? 8'hFC : 8'(a);
            bus.mem_rdata <= 8'h00;
        end else if (bus.mem_write) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end else if (bus.mem_read) begin
            bus.mem_rdata <= mem[bus.mem_addr];
        end
    end

    int vectors = 0;
    int miscompares = 0;
    int excl_viol = 0;
    logic [7:0] exp_r0, exp_r1;

    always @(negedge CLK)
        if ((bus.mem_read && bus.mem_write) || (bus.ack0 && bus.ack1)) excl_viol++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input bit id, input bit on, input bit we, input logic [4:0] addr,
                           input logic [7:0] wd);
        if (id) begin
            bus.req1 = on; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wd;
        end else begin
            bus.req0 = on; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wd;
        end
    endtask

    // Called at a negedge with the arbiter in IDLE; walks ISSUE/STROBE/RESP/IDLE.
    task automatic run_access(input bit id, input bit we, input logic [4:0] addr,
                              input logic [7:0] wd, input logic [7:0] exp_rd, input string tag);
        set_req(id, 1'b1, we, addr, wd);
        @(posedge CLK); @(negedge CLK);
        chk({tag, "_issue_busy"}, bus.busy, 1);
        chk({tag, "_issue_strobe"}, bus.mem_state, 0);
        chk({tag, "_issue_rd"}, bus.mem_read, !we);
        chk({tag, "_issue_wr"}, bus.mem_write, we);
        chk({tag, "_issue_addr"}, bus.mem_addr, addr);
        if (we) chk({tag, "_issue_wdata"}, bus.mem_wdata, wd);
        chk({tag, "_issue_ack"}, {bus.ack1, bus.ack0}, 0);
        @(negedge CLK);
        chk({tag, "_strobe"}, bus.mem_state, 1);
        chk({tag, "_strobe_rd"}, bus.mem_read, !we);
        chk({tag, "_strobe_addr"}, bus.mem_addr, addr);
        chk({tag, "_strobe_ack"}, {bus.ack1, bus.ack0}, 0);
        @(negedge CLK);
        if (!we) begin
            if (id) exp_r1 = exp_rd;
            else    exp_r0 = exp_rd;
        end
        chk({tag, "_resp_ack"}, {bus.ack1, bus.ack0}, id ? 2 : 1);
        chk({tag, "_resp_strobe"}, bus.mem_state, 0);
        chk({tag, "_resp_en"}, {bus.mem_read, bus.mem_write}, 0);
        chk({tag, "_resp_rdata0"}, bus.rdata0, exp_r0);
        chk({tag, "_resp_rdata1"}, bus.rdata1, exp_r1);
        set_req(id, 1'b0, we, addr, wd);
        @(negedge CLK);
        chk({tag, "_idle_busy"}, bus.busy, 0);
        chk({tag, "_idle_ack"}, {bus.ack1, bus.ack0}, 0);
        chk({tag, "_idle_addr_hold"}, bus.mem_addr, addr);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_ack"}, {bus.ack1, bus.ack0}, 0);
        chk({tag, "_mem_ctl"}, {bus.mem_state, bus.mem_read, bus.mem_write}, 0);
        chk({tag, "_mem_addr"}, bus.mem_addr, 0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
        chk({tag, "_rdata"}, {bus.rdata1, bus.rdata0}, 0);
    endtask

    int n_ack;
    int n_strobe;

    initial begin
        set_req(1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
        set_req(1'b1, 1'b0, 1'b0, 5'd0, 8'h00);
        #1 RST = 1'b1;
        exp_r0 = 8'h00;
        exp_r1 = 8'h00;
        @(negedge CLK); @(negedge CLK);
        chk_reset("reset");
        RST = 1'b0;

        run_access(1'b0, 1'b0, 5'd3, 8'h00, 8'h03, "rd3");
        run_access(1'b1, 1'b1, 5'd17, 8'h55, 8'h00, "wr17");
        run_access(1'b1, 1'b0, 5'd17, 8'h00, 8'h55, "rd17");

        // Both requesters held: expect grants 0,1,0,1 with acks 4 cycles apart.
        set_req(1'b0, 1'b1, 1'b0, 5'd7, 8'h00);
        set_req(1'b1, 1'b1, 1'b0, 5'd9, 8'h00);
        n_ack = 0;
        n_strobe = 0;
        for (int k = 1; k <= 18; k++) begin
            @(negedge CLK);
            if (bus.mem_state) n_strobe++;
            if (bus.ack0 || bus.ack1) begin
                chk("rr_ack_id", {31'b0, bus.ack1}, n_ack % 2);
                chk("rr_ack_cycle", k, 3 + 4 * n_ack);
                if (bus.ack1) chk("rr_rdata1", bus.rdata1, 8'h09);
                else          chk("rr_rdata0", bus.rdata0, 8'h07);
                n_ack++;
                if (n_ack == 4) begin
                    set_req(1'b0, 1'b0, 1'b0, 5'd7, 8'h00);
                    set_req(1'b1, 1'b0, 1'b0, 5'd9, 8'h00);
                end
            end
        end
        chk("rr_ack_count", n_ack, 4);
        chk("rr_strobe_count", n_strobe, 4);
        exp_r0 = 8'h07;
        exp_r1 = 8'h09;

        run_access(1'b0, 1'b0, 5'd20, 8'h00, 8'hFC, "rd20");

        // Reset during STROBE: access dropped, no ack, everything cleared.
        set_req(1'b0, 1'b1, 1'b0, 5'd5, 8'h00);
        @(posedge CLK); @(negedge CLK);
        @(negedge CLK);
        chk("rst_mid_in_strobe", bus.mem_state, 1);
        RST = 1'b1;
        set_req(1'b0, 1'b0, 1'b0, 5'd5, 8'h00);
        exp_r0 = 8'h00;
        exp_r1 = 8'h00;
        @(negedge CLK);
        chk_reset("rst_mid");
        RST = 1'b0;
        run_access(1'b0, 1'b0, 5'd5, 8'h00, 8'h05, "rd5");

        // req0 alone held continuously: granted every 4 cycles.
        set_req(1'b0, 1'b1, 1'b0, 5'd1, 8'h00);
        n_ack = 0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge CLK);
            if (bus.ack0 || bus.ack1) begin
                chk("cont_ack0", {bus.ack1, bus.ack0}, 1);
                chk("cont_cycle", k, 3 + 4 * n_ack);
                chk("cont_rdata0", bus.rdata0, 8'h01);
                n_ack++;
                if (n_ack == 3) set_req(1'b0, 1'b0, 1'b0, 5'd1, 8'h00);
            end
        end
        chk("cont_ack_count", n_ack, 3);
        chk("exclusive_enables_acks", excl_viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/data_memory_arbiter.md
DATA_MEMORY_ARBITER -- requirements
Module: data_memory_arbiter

Interface
REQ-001 Parameter ADDR_W, 5, memory address width (32 entries).
REQ-002 Parameter DATA_W, 8, memory data width.
REQ-003 CLK  in  1  system clock; all state on rising edge.
REQ-004 RST  in  1  reset, asynchronous, active-high.
REQ-005 req0/req1  in  1  access request, requester 0/1; level, held until ack.
REQ-006 we0/we1  in  1  1 = write, 0 = read; stable while req high.
REQ-007 addr0/addr1  in  ADDR_W  target address; stable while req high.
REQ-008 wdata0/wdata1  in  DATA_W  write data; stable while req high.
REQ-009 ack0/ack1  out  1  one-cycle completion pulse to requester 0/1.
REQ-010 rdata0/rdata1  out  DATA_W  read result; valid in ack cycle, held until that requester's next read ack.
REQ-011 busy  out  1  high whenever FSM not in IDLE.
REQ-012 mem_state  out  1  memory strobe; memory acts on its rising edge.
REQ-013 mem_addr  out  ADDR_W  memory address.
REQ-014 mem_wdata  out  DATA_W  memory write data.
REQ-015 mem_read/mem_write  out  1  memory read/write enables; never both high.
REQ-016 mem_rdata  in  DATA_W  memory read data, updated by memory on mem_state rising edge.

Function
REQ-017 FSM states IDLE, ISSUE, STROBE, RESP; all outputs registered.
REQ-018 IDLE: no request -> stay; any request -> latch winner id, we, addr, wdata; go ISSUE.
REQ-019 Arbitration: single request wins; both high -> requester not granted last wins (round-robin); last-grant pointer updates on each grant.
REQ-020 ISSUE: drive mem_addr, mem_wdata, mem_read = ~we, mem_write = we; mem_state low; go STROBE.
REQ-021 STROBE: mem_state high for exactly one cycle, addr/data/enables unchanged; go RESP.
REQ-022 RESP: mem_state low; pulse ack of winner; on read, load that requester's rdata from mem_rdata sampled at end of STROBE; go IDLE.
REQ-023 Latency: req sampled in IDLE cycle N -> ack in cycle N+3; back-to-back throughput one access per 4 cycles.
REQ-024 Requester deasserts req on the edge where its ack is high; arbiter does not sample req outside IDLE; req still high in the next IDLE is a new request.
REQ-025 Outside ISSUE/STROBE: mem_read = mem_write = 0; mem_addr/mem_wdata hold last value.
REQ-026 Write access leaves rdata of both requesters unchanged.
REQ-027 Request from the loser stays pending and is granted in the IDLE cycle after the current RESP.
REQ-028 At most one ack high per cycle; ack never high outside RESP.

Reset
REQ-029 RST asserted: FSM -> IDLE, ack0/ack1/busy/mem_state/mem_read/mem_write = 0, mem_addr/mem_wdata/rdata0/rdata1 = 0, last-grant pointer = 1 (requester 0 favoured first).
REQ-030 RST mid-access: access abandoned without ack; requester re-issues; memory contents governed by shared RST.
REQ-031 First arbitration occurs on the first rising CLK edge after RST deasserts.

Structure
REQ-032 Shared package holds ADDR_W, DATA_W defaults and the FSM state encoding (2-bit).
REQ-033 One sub-module rr_pick2: combinational 2-way round-robin picker (req[1:0], last -> grant id, valid).
REQ-034 Memory is instantiated outside; arbiter connects only via mem_* ports.

Verification
REQ-035 After reset, req0 read addr 3 -> mem_read high ISSUE/STROBE, ack0 at N+3, rdata0 = 3.
REQ-036 req1 write addr 17 data 0x55, then req1 read addr 17 -> ack1 twice, rdata1 = 0x55, rdata0 unchanged.
REQ-037 req0 and req1 both high same cycle, held -> grant order 0,1,0,1; each ack spaced 4 cycles.
REQ-038 req0 read addr 20 -> rdata0 = 0xFC; mem_state high exactly one cycle per access.
REQ-039 RST asserted during STROBE -> no ack, all outputs 0 next cycle; re-issued read addr 5 -> rdata0 = 5.
REQ-040 Continuous req0 only -> granted every 4 cycles, no starvation check needed; mem_read and mem_write never both high.
